// File: rtl/ugemm_sys_array_if.sv
// Job/result handshake bundle for the unary GEMM systolic array.
// master = job source / result sink, slave = the array itself.
interface ugemm_sys_array_if #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 24
);
  logic                           start_valid;
  logic                           start_ready;
  logic                           acc_keep;
  logic [HEIGHT-1:0][IWIDTH-1:0]  ifm;
  logic [WIDTH-1:0][IWIDTH-1:0]   wght;
  logic                           busy;
  logic                           ofm_valid;
  logic                           ofm_ready;
  logic [WIDTH-1:0][OWIDTH-1:0]   ofm;

  modport master (
    output start_valid, acc_keep, ifm, wght, ofm_ready,
    input  start_ready, busy, ofm_valid, ofm
  );

  modport slave (
    input  start_valid, acc_keep, ifm, wght, ofm_ready,
    output start_ready, busy, ofm_valid, ofm
  );
endinterface

// File: rtl/ugemm_sys_array.sv
// Unary (bitstream) GEMM systolic array. Each row's activation is quantised
// to BSL bits and turned into a bit-reversed-counter stream that ripples
// across the row; every PE adds its stationary weight on a 1 bit, so after
// 2^BSL stream bits the accumulator grows by exactly ifmq * weight.
// Supported parameters: OWIDTH >= IWIDTH+BSL and 1 <= BSL <= IWIDTH.
module ugemm_sys_array #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 24,
  parameter int BSL    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ugemm_sys_array_if.slave bus
);

  localparam int RUN_LEN = (1 << BSL) + WIDTH - 1;
  localparam int CW      = $clog2(RUN_LEN + HEIGHT + 1);
  localparam logic [CW-1:0]     STREAM_END = CW'(1 << BSL);
  localparam logic [CW-1:0]     LOAD_LAST  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0]     RUN_LAST   = CW'(RUN_LEN - 1);
  localparam logic [OWIDTH-1:0] ACC_MAX    = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          beat_fire;

  logic [HEIGHT-1:0][BSL-1:0]                ifmq;
  logic [HEIGHT-1:0][WIDTH-1:0][IWIDTH-1:0]  wreg;
  logic [HEIGHT-1:0][WIDTH-1:0]              stream;
  logic [HEIGHT-1:0][WIDTH-1:0][OWIDTH-1:0]  acc;
  logic [HEIGHT-1:0][WIDTH-1:0][OWIDTH-1:0]  sat_sum;

  logic [CW-1:0]     feed_cnt;
  logic              feed_en;
  logic [BSL-1:0]    rng;
  logic [HEIGHT-1:0] gen;

  // State and shared phase counter (LOAD row, RUN cycle, DRAIN beat)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sequencing and handshake outputs; DRAIN shows the row selected by cnt
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    accept          = (state == IDLE) && bus.start_valid;
    beat_fire       = (state == DRAIN) && bus.ofm_ready;
    bus.start_ready = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.ofm_valid   = (state == DRAIN);
    bus.ofm         = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        for (int h = 0; h < HEIGHT; h++) begin
          if (cnt == CW'(h)) bus.ofm = acc[h];
        end
        if (beat_fire) begin
          if (cnt == LOAD_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Column-0 stream bits, generated one cycle ahead so the first PE flop holds bit c during RUN cycle c
  always_comb begin
    feed_cnt = '0;
    feed_en  = 1'b0;
    if (state == LOAD && cnt == LOAD_LAST) begin
      feed_en = 1'b1;
    end else if (state == RUN) begin
      feed_cnt = cnt + CW'(1);
      feed_en  = 1'b1;
    end
    for (int i = 0; i < BSL; i++) rng[i] = feed_cnt[BSL-1-i];
    for (int h = 0; h < HEIGHT; h++) begin
      gen[h] = feed_en && (feed_cnt < STREAM_END) && (ifmq[h] > rng);
    end
  end

  // Saturating accumulator candidates: a carry out of OWIDTH pins the result at all-ones
  always_comb begin
    logic [OWIDTH:0] wide;
    wide    = '0;
    sat_sum = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      for (int w = 0; w < WIDTH; w++) begin
        wide = {1'b0, acc[h][w]} + (OWIDTH+1)'(wreg[h][w]);
        sat_sum[h][w] = wide[OWIDTH] ? ACC_MAX : wide[OWIDTH-1:0];
      end
    end
  end

  // PE datapath: activation capture, weight shift-in, stream ripple and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifmq   <= '0;
      wreg   <= '0;
      stream <= '0;
      acc    <= '0;
    end else begin
      if (accept) begin
        for (int h = 0; h < HEIGHT; h++) ifmq[h] <= bus.ifm[h][IWIDTH-1 -: BSL];
        if (!bus.acc_keep) acc <= '0;
      end
      if (state == LOAD) begin
        wreg[0] <= bus.wght;
        for (int h = 1; h < HEIGHT; h++) wreg[h] <= wreg[h-1];
      end
      for (int h = 0; h < HEIGHT; h++) begin
        stream[h][0] <= gen[h];
        for (int w = 1; w < WIDTH; w++) stream[h][w] <= stream[h][w-1];
      end
      if (state == RUN) begin
        for (int h = 0; h < HEIGHT; h++) begin
          for (int w = 0; w < WIDTH; w++) begin
            if (stream[h][w]) acc[h][w] <= sat_sum[h][w];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ugemm_sys_array.sv
// Directed, table-driven bench for ugemm_sys_array: whole jobs with
// hand-computed results, plus backpressure and mid-RUN reset sequences.
module tb_ugemm_sys_array;

  localparam int HEIGHT  = 4;
  localparam int WIDTH   = 4;
  localparam int IWIDTH  = 16;
  localparam int OWIDTH  = 24;
  localparam int BSL     = 8;
  localparam int LATENCY = 263;

  typedef struct {
    logic [HEIGHT-1:0][IWIDTH-1:0]             ifm;
    logic [HEIGHT-1:0][WIDTH-1:0][IWIDTH-1:0]  wbeat;
    logic                                      acc_keep;
    logic [HEIGHT-1:0][WIDTH-1:0][OWIDTH-1:0]  exp;
  } vec_t;

  localparam int E1 [4][4] = '{'{0, 0, 0, 0}, '{255, 510, 765, 1020},
                               '{255, 510, 765, 1020}, '{255, 510, 765, 1020}};
  localparam int E4 [4][4] = '{'{0, 0, 0, 0}, '{5, 6, 7, 8},
                               '{320, 384, 448, 512}, '{960, 1152, 1344, 1536}};
  localparam int E5 [4][4] = '{'{2, 2, 2, 2}, '{7, 8, 9, 10},
                               '{322, 386, 450, 514}, '{962, 1154, 1346, 1538}};
  localparam int IFM4 [4]  = '{'h0000, 'h0100, 'h4000, 'hC012};

  logic clk;
  logic rst_n;
  int   asserts;
  int   fails;
  vec_t vecs [7];

  ugemm_sys_array_if #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH)) bus ();

  ugemm_sys_array #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .BSL(BSL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRow(input string name, input int k, input vec_t v);
    for (int w = 0; w < WIDTH; w++) begin
      checkOutput($sformatf("%s[%0d][%0d]", name, k, w), 32'(bus.ofm[w]), 32'(v.exp[k][w]));
    end
  endtask

  task automatic fillUniform(input int idx, input logic [IWIDTH-1:0] ifm_val,
                             input logic [IWIDTH-1:0] w_val, input logic keep,
                             input logic [OWIDTH-1:0] e_val);
    vecs[idx].acc_keep = keep;
    for (int h = 0; h < HEIGHT; h++) begin
      vecs[idx].ifm[h] = ifm_val;
      for (int w = 0; w < WIDTH; w++) begin
        vecs[idx].wbeat[h][w] = w_val;
        vecs[idx].exp[h][w]   = e_val;
      end
    end
  endtask

  // One whole job: accept, four weight beats, latency check, then drain.
  // stall_beat >= 0 holds ofm_ready low for 5 cycles on that beat and pulses start_valid.
  task automatic applyStimulus(input vec_t v, input int stall_beat);
    int lat;
    @(negedge clk);
    checkOutput("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.ifm         = v.ifm;
    bus.acc_keep    = v.acc_keep;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.ifm         = '0;
    bus.wght        = v.wbeat[0];
    lat = -1;
    for (int e = 1; e <= 400 && lat < 0; e++) begin
      @(posedge clk);
      #1;
      if (e < HEIGHT) bus.wght = v.wbeat[e];
      else bus.wght = '1;
      if (e == 1) begin
        checkOutput("busy_load", 32'(bus.busy), 32'd1);
        checkOutput("start_ready_busy", 32'(bus.start_ready), 32'd0);
      end
      if (bus.ofm_valid === 1'b1) lat = e;
    end
    checkOutput("latency", 32'(lat), 32'(LATENCY));
    if (lat < 0) return;
    for (int k = 0; k < HEIGHT; k++) begin
      if (k == stall_beat) begin
        bus.ofm_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (s == 2) bus.start_valid = 1'b1;
          if (s == 3) bus.start_valid = 1'b0;
          @(posedge clk);
          #1;
          checkOutput("stall_valid", 32'(bus.ofm_valid), 32'd1);
          checkRow("stall_ofm", k, v);
        end
        checkOutput("stall_start_ready", 32'(bus.start_ready), 32'd0);
        bus.ofm_ready = 1'b1;
      end
      checkOutput("beat_valid", 32'(bus.ofm_valid), 32'd1);
      checkRow("ofm", k, v);
      @(posedge clk);
      #1;
    end
    checkOutput("done_valid", 32'(bus.ofm_valid), 32'd0);
    checkOutput("done_busy", 32'(bus.busy), 32'd0);
    checkOutput("done_start_ready", 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    asserts = 0;
    fails   = 0;

    // Vector table: {ifm rows, weight beats, acc_keep, expected rows}
    fillUniform(0, 16'h8000, 16'd3, 1'b0, 24'd384);
    fillUniform(1, 16'hFFFF, 16'd0, 1'b0, 24'd0);
    for (int b = 0; b < HEIGHT; b++)
      for (int w = 0; w < WIDTH; w++) vecs[1].wbeat[b][w] = (b == 3) ? 16'd0 : 16'(w + 1);
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++) vecs[1].exp[h][w] = 24'(E1[h][w]);
    fillUniform(2, 16'hFFFF, 16'hFFFF, 1'b0, 24'd16711425);
    fillUniform(3, 16'hFFFF, 16'hFFFF, 1'b1, 24'hFFFFFF);
    fillUniform(4, 16'h0000, 16'd0, 1'b0, 24'd0);
    for (int h = 0; h < HEIGHT; h++) begin
      vecs[4].ifm[h] = 16'(IFM4[h]);
      for (int w = 0; w < WIDTH; w++) begin
        vecs[4].wbeat[h][w] = 16'(w + 5);
        vecs[4].exp[h][w]   = 24'(E4[h][w]);
      end
    end
    fillUniform(5, 16'h0100, 16'd2, 1'b1, 24'd0);
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++) vecs[5].exp[h][w] = 24'(E5[h][w]);
    fillUniform(6, 16'h0100, 16'd7, 1'b1, 24'd7);

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.acc_keep    = 1'b0;
    bus.ifm         = '0;
    bus.wght        = '0;
    bus.ofm_ready   = 1'b1;

    // Reset state, during and after reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_start_ready", 32'(bus.start_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.ofm_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_start_ready", 32'(bus.start_ready), 32'd1);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_valid", 32'(bus.ofm_valid), 32'd0);
    for (int w = 0; w < WIDTH; w++)
      checkOutput($sformatf("post_rst_ofm[%0d]", w), 32'(bus.ofm[w]), 32'd0);

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      $display("[TB] job %0d", i);
      applyStimulus(vecs[i], -1);
    end

    // Backpressure on beat 1 with a start_valid pulse during DRAIN
    $display("[TB] backpressure job");
    applyStimulus(vecs[4], 1);

    // Reset in the middle of RUN (c = 100), then a fresh job with acc_keep=1
    $display("[TB] mid-run reset");
    @(negedge clk);
    bus.ifm         = {HEIGHT{16'h8000}};
    bus.acc_keep    = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.wght        = {WIDTH{16'd3}};
    for (int e = 1; e <= HEIGHT + 100; e++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_start_ready", 32'(bus.start_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(bus.ofm_valid), 32'd0);
    for (int w = 0; w < WIDTH; w++)
      checkOutput($sformatf("mid_rst_ofm[%0d]", w), 32'(bus.ofm[w]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_rst_hold_valid", 32'(bus.ofm_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (bus.ofm_valid !== 1'b0) checkOutput("no_beat_after_abort", 32'(bus.ofm_valid), 32'd0);
    end
    checkOutput("abort_idle", 32'(bus.start_ready), 32'd1);
    applyStimulus(vecs[6], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/ugemm_sys_array.md
UGEMM_SYS_ARRAY -- requirements
Module: ugemm_sys_array

Interface
REQ-001 SHALL have parameters: HEIGHT, 4, PE rows; WIDTH, 4, PE columns; IWIDTH, 16, ifm/weight width; OWIDTH, 24, accumulator width; BSL, 8, log2 of bitstream length.
REQ-002 SHALL require OWIDTH >= IWIDTH+BSL and 1 <= BSL <= IWIDTH; other values are unsupported.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start_valid  in  1  job request.
REQ-006 start_ready  out  1  high only in IDLE.
REQ-007 acc_keep  in  1  sampled at start accept: 1 keeps accumulators, 0 clears them.
REQ-008 ifm  in  [IWIDTH-1:0] x HEIGHT  per-row activations, sampled at start accept.
REQ-009 wght  in  [IWIDTH-1:0] x WIDTH  weight beat, sampled once per LOAD cycle.
REQ-010 busy  out  1  high in LOAD, RUN and DRAIN.
REQ-011 ofm_valid  out  1  result beat valid.
REQ-012 ofm_ready  in  1  result sink ready.
REQ-013 ofm  out  [OWIDTH-1:0] x WIDTH  one PE row of accumulators per beat.

Function
REQ-014 SHALL run FSM IDLE -> LOAD -> RUN -> DRAIN -> IDLE, with no other transitions except reset.
REQ-015 IDLE: start_valid & start_ready accepts the job.
- Latches ifmq[h] = ifm[h][IWIDTH-1 -: BSL].
- Clears every accumulator unless acc_keep=1.
- Next state is LOAD.
REQ-016 LOAD lasts exactly HEIGHT cycles; each cycle shifts wght into row 0 and shifts each row's weights down one row; afterwards row h holds the beat from LOAD cycle HEIGHT-1-h.
REQ-017 RUN lasts exactly 2^BSL+WIDTH-1 cycles, counted by cycle counter c = 0 .. 2^BSL+WIDTH-2.
REQ-018 RNG SHALL be r(c) = bit-reversal of c[BSL-1:0]; for c < 2^BSL, row h column-0 stream bit = (ifmq[h] > r(c)); for c >= 2^BSL the bit is 0.
REQ-019 Stream bits SHALL advance one column per cycle through a per-PE flop; PE(h,w) adds its weight to its accumulator when its incoming bit is 1.
REQ-020 After RUN, PE(h,w) accumulator increase SHALL equal exactly ifmq[h] * weight(h,w), because the bit-reversed sequence is exact over 2^BSL cycles.
REQ-021 Accumulator add SHALL saturate at 2^OWIDTH-1 and never wrap.
REQ-022 DRAIN emits HEIGHT beats: beat k has ofm[w] = acc(k,w) with ofm_valid=1.
- A beat advances only on ofm_valid & ofm_ready.
- ofm is held stable while ofm_ready=0.
- After beat HEIGHT-1 is accepted, next state is IDLE and ofm_valid=0.
REQ-023 Latency: with ofm_ready=1, first ofm_valid SHALL rise exactly HEIGHT+2^BSL+WIDTH-1 cycles after the accept edge (263 at defaults).
REQ-024 start_valid SHALL be ignored outside IDLE; ifm and wght are don't-care outside their sampling cycles.
REQ-025 Accumulators SHALL be unchanged outside RUN, except by the start-accept clear and by reset.

Reset
REQ-026 rst_n low SHALL immediately, independent of clk, force:
- state=IDLE and counters=0.
- All accumulators, weights, stream flops and ifmq = 0.
- ofm_valid=0, busy=0, ofm=0, start_ready=1.
REQ-027 Reset asserted mid-job SHALL abort the job with no further ofm beats; the first job after release SHALL behave as if from power-up.

Verification
REQ-028 Reset: hold rst_n=0 then release -> start_ready=1, busy=0, ofm_valid=0, all ofm=0.
REQ-029 Basic job: ifm all 0x8000, all 4 LOAD beats wght=3, acc_keep=0 -> ofm_valid at cycle 263, 4 beats each ofm[w]=384 (0x180).
REQ-030 Row mapping: LOAD beats 0..3 carry wght[w]=w+1 everywhere except beat 3 = 0, ifm=0xFFFF -> beat 0 (row 0) ofm={0,0,0,0}, beats 1..3 ofm[w]=255*(w+1).
REQ-031 Accumulate and saturate: job ifm=0xFFFF, wght=0xFFFF, acc_keep=0 -> 16711425; repeat with acc_keep=1 -> 0xFFFFFF (saturated).
REQ-032 Backpressure: ofm_ready low 5 cycles on beat 1 -> ofm and ofm_valid stable, no beat lost, 4 beats total; start_valid pulsed during DRAIN is ignored.
REQ-033 Mid-RUN reset: assert rst_n at RUN c=100 -> outputs at reset values at once; a following job with ifm=0x0100 (ifmq=1), wght=7 -> ofm=7 everywhere.
